// File: rtl/wb_decoder.sv
// wb_decoder: single-master to NUM_SLAVES Wishbone address decoder.
//
// Each master access is decoded against a per-slave {prefix, mask} rule while
// the block is idle. The lowest-indexed matching slave is latched into sel and
// receives cyc/stb from the next cycle on. The slave's ack/err/read data are
// returned to the master combinationally. An unmatched address produces a
// one-cycle error response. A slave that never answers is cut off by a 16-bit
// watchdog. The first faulting address is held in a sticky error register.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rules_i              per slave {prefix, mask}; slave i at bits
//                        [i*2*ADDR_WIDTH +: 2*ADDR_WIDTH], prefix in upper half
//   m_cyc_i, m_stb_i     master cycle / strobe
//   m_we_i, m_adr_i      master write enable / address
//   m_dat_i, m_sel_i     master write data / byte select
//   m_dat_o              read data to master (zero unless busy)
//   m_ack_o, m_err_o     acknowledge / error to master
//   s_cyc_o, s_stb_o     per-slave cycle / strobe (one-hot while busy)
//   s_we_o .. s_sel_o    request fields shared by all slaves
//   s_dat_i              per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_ack_i, s_err_i     per-slave acknowledge / error
//   err_valid_o          sticky: decode error or timeout seen
//   err_adr_o            address of the first faulting access
//   err_clr_i            clears err_valid_o / err_adr_o (wins over a capture)

module wb_decoder #(
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_SLAVES*2*ADDR_WIDTH-1:0] rules_i,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  input  logic                             m_we_i,
  input  logic [ADDR_WIDTH-1:0]            m_adr_i,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  output logic                             s_we_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  output logic [DATA_WIDTH/8-1:0]          s_sel_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES-1:0]            s_err_i,
  output logic                             err_valid_o,
  output logic [ADDR_WIDTH-1:0]            err_adr_o,
  input  logic                             err_clr_i
);

  localparam int unsigned SelWidth   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [SelWidth-1:0]   sel_q, sel_d;
  logic [15:0]           wdog_q, wdog_d;
  logic                  err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0] err_adr_q, err_adr_d;

  // Address decode
  logic [NUM_SLAVES-1:0] match;
  logic                  hit;
  logic [SelWidth-1:0]   hit_idx;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      match[i] = ((m_adr_i & rules_i[i*2*ADDR_WIDTH +: ADDR_WIDTH])
                  ^ rules_i[i*2*ADDR_WIDTH+ADDR_WIDTH +: ADDR_WIDTH]) == '0;
    end
  end

  // Lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && match[i]) begin
        hit     = 1'b1;
        hit_idx = SelWidth'(i);
      end
    end
  end

  // Selected slave response
  logic                  sel_ack;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [NUM_SLAVES-1:0] sel_onehot;

  // Compare-based mux keeps indexing in range for any NUM_SLAVES.
  always_comb begin
    sel_ack    = 1'b0;
    sel_err    = 1'b0;
    sel_dat    = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SelWidth'(i)) begin
        sel_ack       = s_ack_i[i];
        sel_err       = s_err_i[i];
        sel_dat       = s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  logic req;
  logic decode_err;
  logic timeout;

  assign req        = m_cyc_i & m_stb_i;
  assign decode_err = (state_q == StIdle) && req && !hit;
  // A real slave response in the limit cycle takes precedence over the timeout.
  assign timeout    = (state_q == StBusy) && m_cyc_i && !sel_ack && !sel_err &&
                      (wdog_q >= TimeoutVal);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      wdog_q      <= '0;
      err_valid_q <= 1'b0;
      err_adr_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wdog_q      <= wdog_d;
      err_valid_q <= err_valid_d;
      err_adr_q   <= err_adr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            state_d = StBusy;
            sel_d   = hit_idx;
            wdog_d  = '0;
          end else begin
            state_d = StErr;
          end
        end
      end
      StBusy: begin
        if (!m_cyc_i || sel_ack || sel_err || timeout) begin
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sticky error capture; a clear wins over a simultaneous capture.
  always_comb begin
    err_valid_d = err_valid_q;
    err_adr_d   = err_adr_q;
    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_adr_d   = '0;
    end else if ((decode_err || timeout) && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_adr_d   = m_adr_i;
    end
  end

  // Output logic
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_dat_o = '0;
    unique case (state_q)
      StBusy: begin
        s_cyc_o = sel_onehot;
        s_stb_o = sel_onehot;
        m_dat_o = sel_dat;
        // An abandoned cycle gets no response.
        if (m_cyc_i) begin
          m_ack_o = sel_ack;
          m_err_o = sel_err | timeout;
        end
      end
      StErr: begin
        m_err_o = m_cyc_i;
      end
      default: begin
      end
    endcase
  end

  assign s_we_o      = m_we_i;
  assign s_adr_o     = m_adr_i;
  assign s_dat_o     = m_dat_i;
  assign s_sel_o     = m_sel_i;
  assign err_valid_o = err_valid_q;
  assign err_adr_o   = err_adr_q;

endmodule

// File: tb/tb_wb_decoder.sv
// Directed bench for wb_decoder with two slaves and a 4-cycle watchdog.
module tb_wb_decoder;

  logic         clk_i;
  logic         rst_ni;
  logic [127:0] rules_i;
  logic         m_cyc_i;
  logic         m_stb_i;
  logic         m_we_i;
  logic [31:0]  m_adr_i;
  logic [31:0]  m_dat_i;
  logic [3:0]   m_sel_i;
  logic [31:0]  m_dat_o;
  logic         m_ack_o;
  logic         m_err_o;
  logic [1:0]   s_cyc_o;
  logic [1:0]   s_stb_o;
  logic         s_we_o;
  logic [31:0]  s_adr_o;
  logic [31:0]  s_dat_o;
  logic [3:0]   s_sel_o;
  logic [63:0]  s_dat_i;
  logic [1:0]   s_ack_i;
  logic [1:0]   s_err_i;
  logic         err_valid_o;
  logic [31:0]  err_adr_o;
  logic         err_clr_i;

  int total = 0;
  int bad   = 0;

  wb_decoder #(
    .NUM_SLAVES    (2),
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rules_i    (rules_i),
    .m_cyc_i    (m_cyc_i),
    .m_stb_i    (m_stb_i),
    .m_we_i     (m_we_i),
    .m_adr_i    (m_adr_i),
    .m_dat_i    (m_dat_i),
    .m_sel_i    (m_sel_i),
    .m_dat_o    (m_dat_o),
    .m_ack_o    (m_ack_o),
    .m_err_o    (m_err_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_we_o     (s_we_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_sel_o    (s_sel_o),
    .s_dat_i    (s_dat_i),
    .s_ack_i    (s_ack_i),
    .s_err_i    (s_err_i),
    .err_valid_o(err_valid_o),
    .err_adr_o  (err_adr_o),
    .err_clr_i  (err_clr_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_rules(input logic [31:0] p0, input logic [31:0] k0,
                           input logic [31:0] p1, input logic [31:0] k1);
    rules_i = {p1, k1, p0, k0};
  endtask

  task automatic req(input logic [31:0] adr, input logic we);
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = adr;
    m_we_i  = we;
  endtask

  task automatic idle_master();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
  endtask

  initial begin
    rst_ni    = 1'b0;
    m_cyc_i   = 1'b0;
    m_stb_i   = 1'b0;
    m_we_i    = 1'b0;
    m_adr_i   = '0;
    m_dat_i   = '0;
    m_sel_i   = '0;
    s_dat_i   = '0;
    s_ack_i   = '0;
    s_err_i   = '0;
    err_clr_i = 1'b0;
    set_rules(32'h0000_0000, 32'hF000_0000, 32'h1000_0000, 32'hF000_0000);

    // Reset state
    #12;
    chk("rst_stb", 64'(s_stb_o), 64'h0);
    chk("rst_cyc", 64'(s_cyc_o), 64'h0);
    chk("rst_ack", 64'(m_ack_o), 64'h0);
    chk("rst_err", 64'(m_err_o), 64'h0);
    chk("rst_evalid", 64'(err_valid_o), 64'h0);
    chk("rst_eadr", 64'(err_adr_o), 64'h0);
    step();
    rst_ni = 1'b1;
    step();

    // Read of slave 1, ack two cycles after its strobe
    req(32'h1000_0004, 1'b0);
    m_sel_i = 4'hF;
    #1;
    chk("rd_c0_stb", 64'(s_stb_o), 64'h0);
    chk("rd_pass_adr", 64'(s_adr_o), 64'h1000_0004);
    chk("rd_pass_sel", 64'(s_sel_o), 64'hF);
    chk("rd_pass_we", 64'(s_we_o), 64'h0);
    step(); #1;
    chk("rd_c1_stb", 64'(s_stb_o), 64'h2);
    chk("rd_c1_cyc", 64'(s_cyc_o), 64'h2);
    chk("rd_c1_ack", 64'(m_ack_o), 64'h0);
    step();
    // Rule change mid-access must not disturb the selected slave.
    set_rules(32'h0000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000);
    #1;
    chk("rd_c2_stb", 64'(s_stb_o), 64'h2);
    chk("rd_c2_ack", 64'(m_ack_o), 64'h0);
    step();
    s_ack_i = 2'b10;
    s_dat_i = {32'hDEAD_BEEF, 32'h1111_1111};
    #1;
    chk("rd_c3_ack", 64'(m_ack_o), 64'h1);
    chk("rd_c3_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
    chk("rd_c3_err", 64'(m_err_o), 64'h0);
    step();
    s_ack_i = 2'b00;
    idle_master();
    set_rules(32'h0000_0000, 32'hF000_0000, 32'h1000_0000, 32'hF000_0000);
    #1;
    chk("rd_c4_stb", 64'(s_stb_o), 64'h0);
    chk("rd_c4_ack", 64'(m_ack_o), 64'h0);
    chk("rd_c4_dat", 64'(m_dat_o), 64'h0);

    // Write to slave 0, immediate ack
    req(32'h0000_0010, 1'b1);
    m_dat_i = 32'hCAFE_F00D;
    m_sel_i = 4'h3;
    #1;
    chk("wr_pass_we", 64'(s_we_o), 64'h1);
    chk("wr_pass_dat", 64'(s_dat_o), 64'hCAFE_F00D);
    step();
    s_ack_i = 2'b01;
    #1;
    chk("wr_c1_stb", 64'(s_stb_o), 64'h1);
    chk("wr_c1_ack", 64'(m_ack_o), 64'h1);
    step();
    s_ack_i = 2'b00;
    idle_master();
    #1;
    chk("wr_c2_stb", 64'(s_stb_o), 64'h0);

    // Overlapping catch-all rules: slave 0 always wins
    set_rules(32'h0, 32'h0, 32'h0, 32'h0);
    req(32'h1000_0000, 1'b0);
    step();
    s_ack_i = 2'b11;
    s_dat_i = {32'hAAAA_AAAA, 32'h5555_5555};
    #1;
    chk("ovl_a_stb", 64'(s_stb_o), 64'h1);
    chk("ovl_a_cyc", 64'(s_cyc_o), 64'h1);
    chk("ovl_a_dat", 64'(m_dat_o), 64'h5555_5555);
    chk("ovl_a_ack", 64'(m_ack_o), 64'h1);
    step();
    s_ack_i = 2'b00;
    m_adr_i = 32'hFFFF_FFF0;
    #1;
    chk("ovl_gap_stb", 64'(s_stb_o), 64'h0);
    step(); #1;
    chk("ovl_b_stb", 64'(s_stb_o), 64'h1);
    s_ack_i = 2'b01;
    step();
    s_ack_i = 2'b00;
    idle_master();
    #1;
    chk("ovl_end_stb", 64'(s_stb_o), 64'h0);

    // Decode error
    set_rules(32'h0000_0000, 32'hF000_0000, 32'h1000_0000, 32'hF000_0000);
    req(32'h2000_0000, 1'b0);
    #1;
    chk("de_c0_err", 64'(m_err_o), 64'h0);
    step(); #1;
    chk("de_c1_err", 64'(m_err_o), 64'h1);
    chk("de_c1_ack", 64'(m_ack_o), 64'h0);
    chk("de_c1_stb", 64'(s_stb_o), 64'h0);
    chk("de_c1_cyc", 64'(s_cyc_o), 64'h0);
    chk("de_evalid", 64'(err_valid_o), 64'h1);
    chk("de_eadr", 64'(err_adr_o), 64'h2000_0000);
    idle_master();
    step(); #1;
    chk("de_c2_err", 64'(m_err_o), 64'h0);

    // Clear, then watchdog timeout on slave 0
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    #1;
    chk("clr_evalid", 64'(err_valid_o), 64'h0);
    chk("clr_eadr", 64'(err_adr_o), 64'h0);
    req(32'h0000_0100, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      chk($sformatf("to1_c%0d_stb", k), 64'(s_stb_o), 64'h1);
      chk($sformatf("to1_c%0d_err", k), 64'(m_err_o), 64'h0);
    end
    step(); #1;
    chk("to1_c5_err", 64'(m_err_o), 64'h1);
    chk("to1_c5_stb", 64'(s_stb_o), 64'h1);
    step();
    idle_master();
    #1;
    chk("to1_c6_stb", 64'(s_stb_o), 64'h0);
    chk("to1_c6_err", 64'(m_err_o), 64'h0);
    chk("to1_evalid", 64'(err_valid_o), 64'h1);
    chk("to1_eadr", 64'(err_adr_o), 64'h0000_0100);

    // Second timeout must not overwrite the captured address
    req(32'h1000_0200, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      chk($sformatf("to2_c%0d_stb", k), 64'(s_stb_o), 64'h2);
      chk($sformatf("to2_c%0d_err", k), 64'(m_err_o), 64'h0);
    end
    step(); #1;
    chk("to2_c5_err", 64'(m_err_o), 64'h1);
    step();
    idle_master();
    #1;
    chk("to2_c6_stb", 64'(s_stb_o), 64'h0);
    chk("to2_evalid", 64'(err_valid_o), 64'h1);
    chk("to2_eadr", 64'(err_adr_o), 64'h0000_0100);

    // Master abandons the cycle while busy
    req(32'h1000_0008, 1'b0);
    step(); #1;
    chk("ab_c1_stb", 64'(s_stb_o), 64'h2);
    step();
    idle_master();
    s_ack_i = 2'b10;
    #1;
    chk("ab_c2_ack", 64'(m_ack_o), 64'h0);
    chk("ab_c2_err", 64'(m_err_o), 64'h0);
    step();
    s_ack_i = 2'b00;
    #1;
    chk("ab_c3_stb", 64'(s_stb_o), 64'h0);

    // Clear coincides with a decode error capture
    req(32'h2000_0000, 1'b0);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    #1;
    chk("cc_c1_err", 64'(m_err_o), 64'h1);
    chk("cc_c1_evalid", 64'(err_valid_o), 64'h0);
    chk("cc_c1_eadr", 64'(err_adr_o), 64'h0);
    idle_master();
    step(); #1;
    chk("cc_c2_evalid", 64'(err_valid_o), 64'h0);

    // Reset in the middle of an access
    req(32'h3000_0000, 1'b0);
    step();
    idle_master();
    #1;
    chk("rr_pre_evalid", 64'(err_valid_o), 64'h1);
    step();
    req(32'h1000_000C, 1'b0);
    step(); #1;
    chk("rr_busy_stb", 64'(s_stb_o), 64'h2);
    rst_ni = 1'b0;
    #1;
    chk("rr_rst_stb", 64'(s_stb_o), 64'h0);
    chk("rr_rst_cyc", 64'(s_cyc_o), 64'h0);
    chk("rr_rst_ack", 64'(m_ack_o), 64'h0);
    chk("rr_rst_err", 64'(m_err_o), 64'h0);
    chk("rr_rst_evalid", 64'(err_valid_o), 64'h0);
    chk("rr_rst_eadr", 64'(err_adr_o), 64'h0);
    step();
    rst_ni = 1'b1;
    m_adr_i = 32'h0000_0004;
    #1;
    chk("rr_c0_stb", 64'(s_stb_o), 64'h0);
    step();
    s_ack_i = 2'b01;
    s_dat_i = {32'h0BAD_0BAD, 32'h1234_5678};
    #1;
    chk("rr_c1_stb", 64'(s_stb_o), 64'h1);
    chk("rr_c1_ack", 64'(m_ack_o), 64'h1);
    chk("rr_c1_dat", 64'(m_dat_o), 64'h1234_5678);
    step();
    s_ack_i = 2'b00;
    idle_master();
    #1;
    chk("rr_c2_stb", 64'(s_stb_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
